// File: rtl/board_io_frontend.sv
`default_nettype none
// ============================================================================
// Module      : board_io_frontend
// Description : Board I/O front end. Synchronises and debounces pushbuttons
//               (press/release pulses, optional auto-repeat), synchronises
//               slide switches and drives registered seven-segment digits
//               with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module board_io_frontend #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int NUM_DIGITS      = 6,
    parameter int BLANK_LEADING   = 1
) (
    input  logic                    clock50,
    input  logic                    reset_n,
    input  logic [NUM_KEYS-1:0]     key_n,
    input  logic [NUM_SW-1:0]       sw,
    input  logic [NUM_KEYS-1:0]     repeat_en,
    output logic [NUM_KEYS-1:0]     key_level,
    output logic [NUM_KEYS-1:0]     key_press,
    output logic [NUM_KEYS-1:0]     key_release,
    output logic [NUM_KEYS-1:0]     key_repeat,
    output logic [NUM_SW-1:0]       sw_sync,
    input  logic [4*NUM_DIGITS-1:0] disp_value,
    input  logic [NUM_DIGITS-1:0]   disp_blank,
    input  logic                    disp_load,
    output logic [7*NUM_DIGITS-1:0] hex_n
);

    localparam int c_DB_W     = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int c_RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W    = ($clog2(c_RPT_SPAN) < 1) ? 1 : $clog2(c_RPT_SPAN);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RPT   = 2'd2;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers; keys idle high (released), switches idle low
    // ------------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_meta_q, key_sync_q;
    logic [NUM_SW-1:0]   sw_meta_q, sw_sync_q;

    // Synchroniser pipeline for all raw pins
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign sw_sync = sw_sync_q;

    // ------------------------------------------------------------------------
    // Per-key debounce and auto-repeat
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [c_DB_W-1:0]  db_cnt_q, db_cnt_d;
        logic               stable_q, stable_d;     // raw-polarity: 1 = released
        logic               press_q, press_d;
        logic               release_q, release_d;
        logic [1:0]         state_q, state_d;
        logic [c_RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic               cancel;
        logic               repeat_pulse;

        // Release or disabling repeat aborts the sequence and wins over a due pulse
        assign cancel = release_q | ~repeat_en[k];

        // Debounce: count consecutive disagreeing samples, flip when enough seen
        always_comb begin
            db_cnt_d  = '0;
            stable_d  = stable_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (key_sync_q[k] != stable_q) begin
                if (db_cnt_q == c_DB_LAST) begin
                    stable_d  = key_sync_q[k];
                    press_d   = stable_q;
                    release_d = ~stable_q;
                end else begin
                    db_cnt_d = db_cnt_q + c_DB_W'(1);
                end
            end
        end

        // Repeat FSM next-state and counter
        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            case (state_q)
                S_IDLE: begin
                    rpt_cnt_d = '0;
                    if (press_q && repeat_en[k]) begin
                        state_d = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (cancel) begin
                        state_d   = S_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == c_DELAY_LAST) begin
                        state_d   = S_RPT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + c_RPT_W'(1);
                    end
                end
                S_RPT: begin
                    if (cancel) begin
                        state_d   = S_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == c_PERIOD_LAST) begin
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + c_RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        // Repeat FSM output: pulse on the terminal count unless cancelled
        always_comb begin
            repeat_pulse = 1'b0;
            case (state_q)
                S_DELAY: repeat_pulse = ~cancel && (rpt_cnt_q == c_DELAY_LAST);
                S_RPT:   repeat_pulse = ~cancel && (rpt_cnt_q == c_PERIOD_LAST);
                default: repeat_pulse = 1'b0;
            endcase
        end

        // Debounce and repeat state registers
        always_ff @(posedge clock50 or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt_q  <= '0;
                stable_q  <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= S_IDLE;
                rpt_cnt_q <= '0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                stable_q  <= stable_d;
                press_q   <= press_d;
                release_q <= release_d;
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end

        assign key_level[k]   = ~stable_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_repeat[k]  = repeat_pulse;
    end

    // ------------------------------------------------------------------------
    // Seven-segment display
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    lead_zero;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_encode = 7'b1000000;
            4'h1:    seg_encode = 7'b1111001;
            4'h2:    seg_encode = 7'b0100100;
            4'h3:    seg_encode = 7'b0110000;
            4'h4:    seg_encode = 7'b0011001;
            4'h5:    seg_encode = 7'b0010010;
            4'h6:    seg_encode = 7'b0000010;
            4'h7:    seg_encode = 7'b1111000;
            4'h8:    seg_encode = 7'b0000000;
            4'h9:    seg_encode = 7'b0010000;
            4'hA:    seg_encode = 7'b0001000;
            4'hB:    seg_encode = 7'b0000011;
            4'hC:    seg_encode = 7'b1000110;
            4'hD:    seg_encode = 7'b0100001;
            4'hE:    seg_encode = 7'b0000110;
            default: seg_encode = 7'b0001110;
        endcase
    endfunction

    // Capture the display value and blank mask on load
    always_comb begin
        value_d = disp_load ? disp_value : value_q;
        blank_d = disp_load ? disp_blank : blank_q;
    end

    // Encode digits from the top down so leading-zero status accumulates
    always_comb begin
        hex_d     = '1;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (value_q[4*i +: 4] == 4'h0);
            if (blank_q[i] || ((BLANK_LEADING != 0) && (i > 0) && lead_zero)) begin
                hex_d[7*i +: 7] = 7'h7F;
            end else begin
                hex_d[7*i +: 7] = seg_encode(value_q[4*i +: 4]);
            end
        end
    end

    // Display capture and segment output registers
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            blank_q <= '1;
            hex_q   <= '1;
        end else begin
            value_q <= value_d;
            blank_q <= blank_d;
            hex_q   <= hex_d;
        end
    end

    assign hex_n = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_board_io_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_frontend
// Description : Self-checking bench for board_io_frontend. Expected outputs
//               for each clock are queued by a reference model; a monitor
//               pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_frontend;

    localparam int NK  = 4;
    localparam int NSW = 10;
    localparam int DB  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;
    localparam int ND  = 6;

    localparam bit [6:0] c_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic              clock50 = 1'b0;
    logic              reset_n;
    logic [NK-1:0]     key_n;
    logic [NSW-1:0]    sw;
    logic [NK-1:0]     repeat_en;
    logic [NK-1:0]     key_level, key_press, key_release, key_repeat;
    logic [NSW-1:0]    sw_sync;
    logic [4*ND-1:0]   disp_value;
    logic [ND-1:0]     disp_blank;
    logic              disp_load;
    logic [7*ND-1:0]   hex_n;

    always #5 clock50 = ~clock50;

    board_io_frontend #(
        .NUM_KEYS(NK), .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .NUM_DIGITS(ND), .BLANK_LEADING(1)
    ) dut (
        .clock50(clock50), .reset_n(reset_n), .key_n(key_n), .sw(sw),
        .repeat_en(repeat_en), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat), .sw_sync(sw_sync),
        .disp_value(disp_value), .disp_blank(disp_blank), .disp_load(disp_load),
        .hex_n(hex_n)
    );

    typedef struct {
        logic [NK-1:0]   lvl;
        logic [NK-1:0]   prs;
        logic [NK-1:0]   rel;
        logic [NK-1:0]   rpt;
        logic [NSW-1:0]  sws;
        logic [7*ND-1:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- reference model state ----------------
    bit [NK-1:0]   m_hist [0:DB+1];   // raw key_n sampled 0..DB+1 edges ago
    bit [NK-1:0]   m_pressed;         // debounced level, 1 = pressed
    bit [NK-1:0]   m_armed;           // auto-repeat sequence in progress
    int            m_press_edge [NK];
    int            m_edge = 0;
    bit [NSW-1:0]  m_sw_prev;
    bit [4*ND-1:0] m_val;
    bit [ND-1:0]   m_blk;

    function automatic bit [7*ND-1:0] ref_hex(input bit [4*ND-1:0] v, input bit [ND-1:0] b);
        bit [7*ND-1:0] r;
        int hi = -1;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < ND; i++) begin
            if (b[i] || (i > 0 && i > hi)) r[7*i +: 7] = 7'h7F;
            else                           r[7*i +: 7] = c_SEG[v[4*i +: 4]];
        end
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_step(output exp_t e);
        m_edge++;
        if (!reset_n) begin
            for (int j = 0; j <= DB + 1; j++) m_hist[j] = '1;
            m_pressed = '0; m_armed = '0; m_sw_prev = '0;
            m_val = '0; m_blk = '1;
            e.lvl = '0; e.prs = '0; e.rel = '0; e.rpt = '0; e.sws = '0; e.hex = '1;
            return;
        end
        e.hex = ref_hex(m_val, m_blk);
        if (disp_load) begin
            m_val = disp_value;
            m_blk = disp_blank;
        end
        e.sws = m_sw_prev;
        m_sw_prev = sw;
        for (int j = DB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = key_n;
        for (int k = 0; k < NK; k++) begin
            bit differ = 1'b1;
            // A key changes once its synchronised level (2 edges late) has
            // disagreed with the debounced level for DB consecutive edges.
            for (int j = 2; j <= DB + 1; j++)
                if (~m_hist[j][k] == m_pressed[k]) differ = 1'b0;
            e.prs[k] = differ && !m_pressed[k];
            e.rel[k] = differ &&  m_pressed[k];
            if (differ) m_pressed[k] = ~m_pressed[k];
            e.lvl[k] = m_pressed[k];
            if (m_armed[k] && (!repeat_en[k] || e.rel[k])) m_armed[k] = 1'b0;
            e.rpt[k] = m_armed[k] && (m_edge - m_press_edge[k] >= RD) &&
                       ((m_edge - m_press_edge[k] - RD) % RP == 0);
            if (e.prs[k]) begin
                m_armed[k]      = 1'b1;
                m_press_edge[k] = m_edge;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    endtask

    // Queue the expectation for the coming edge, then move to the next negedge
    task automatic tick();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clock50);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare every DUT output just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock50);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("key_level",   64'(key_level),   64'(e.lvl));
                check("key_press",   64'(key_press),   64'(e.prs));
                check("key_release", 64'(key_release), 64'(e.rel));
                check("key_repeat",  64'(key_repeat),  64'(e.rpt));
                check("sw_sync",     64'(sw_sync),     64'(e.sws));
                check("hex_n",       64'(hex_n),       64'(e.hex));
            end
        end
    end

    // Stimulus
    initial begin
        reset_n = 1'b0; key_n = '1; sw = '0; repeat_en = '0;
        disp_value = '0; disp_blank = '0; disp_load = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        ticks(2);
        // first load of zero: only digit 0 shows
        disp_load = 1'b1; tick(); disp_load = 1'b0; ticks(3);
        // key 0 press and release
        key_n[0] = 1'b0; ticks(10);
        key_n[0] = 1'b1; ticks(10);
        // key 1 bounce every 2 cycles
        for (int i = 0; i < 10; i++) begin
            key_n[1] = ~key_n[1]; ticks(2);
        end
        key_n[1] = 1'b1; ticks(8);
        // key 2 auto-repeat, then release
        repeat_en[2] = 1'b1;
        key_n[2] = 1'b0; ticks(25);
        key_n[2] = 1'b1; ticks(12);
        // key 2 auto-repeat stopped by repeat_en mid-RPT
        key_n[2] = 1'b0; ticks(19);
        repeat_en[2] = 1'b0; ticks(6);
        key_n[2] = 1'b1; ticks(8);
        repeat_en[2] = 1'b1;
        // display with leading blanking, then forced blank of digit 0
        disp_value = 24'h00A05F; disp_blank = 6'b000000; disp_load = 1'b1; tick();
        disp_load = 1'b0; ticks(3);
        disp_blank = 6'b000001; disp_load = 1'b1; tick();
        disp_load = 1'b0; ticks(3);
        // reset mid-DELAY with key 3 held
        repeat_en[3] = 1'b1;
        key_n[3] = 1'b0; ticks(9);
        reset_n = 1'b0; ticks(2);
        reset_n = 1'b1; ticks(20);
        key_n[3] = 1'b1; ticks(8);

        // randomised traffic
        repeat_en = '1;
        for (int c = 0; c < 3000; c++) begin
            int hold = ((c / 400) % 2 == 0) ? 25 : 4;
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, hold - 1) == 0) key_n[k] = ~key_n[k];
                if ($urandom_range(0, 59) == 0) repeat_en[k] = ~repeat_en[k];
            end
            if ($urandom_range(0, 3) == 0) sw = NSW'($urandom);
            disp_load = ($urandom_range(0, 4) == 0);
            if (disp_load) begin
                logic [4*ND-1:0] v;
                v = (4*ND)'($urandom);
                for (int d = 0; d < ND; d++)
                    if ($urandom_range(0, 2) == 0) v[4*d +: 4] = 4'h0;
                disp_value = v >> (4 * $urandom_range(0, ND));
                disp_blank = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
            end
            reset_n = ($urandom_range(0, 699) != 0);
            tick();
        end
        reset_n = 1'b1; disp_load = 1'b0;
        ticks(4);
        @(posedge clock50);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_io_frontend.md
# board_io_frontend

Parametrised board-I/O front end for the DE1-SoC game top level. It sits between the raw pins (KEY, SW, HEX) and the game logic. It provides synchronised and debounced pushbuttons with press and release pulses and optional auto-repeat, synchronised switches, and a registered multi-digit seven-segment driver with leading-zero blanking. It replaces the direct pin-to-logic wiring used so far.

## Interface

Parameters:
- NUM_KEYS, 4: number of pushbuttons.
- NUM_SW, 10: number of slide switches.
- DEBOUNCE_CYCLES, 500000: stable cycles required before a key changes state (10 ms at 50 MHz). Must be ≥2.
- REPEAT_DELAY, 25000000: cycles from press to the first repeat pulse. Must be ≥2.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses. Must be ≥2.
- NUM_DIGITS, 6: number of seven-segment digits.
- BLANK_LEADING, 1: 1 enables leading-zero blanking.

Ports:
- clock50, in, 1: the single clock, 50 MHz.
- reset_n, in, 1: asynchronous, active-low reset.
- key_n, in, NUM_KEYS: raw pushbuttons, active-low, asynchronous to clock50.
- sw, in, NUM_SW: raw switches, asynchronous to clock50.
- repeat_en, in, NUM_KEYS: per-key auto-repeat enable.
- key_level, out, NUM_KEYS: debounced state, 1 = pressed.
- key_press, out, NUM_KEYS: 1-cycle pulse on a debounced press.
- key_release, out, NUM_KEYS: 1-cycle pulse on a debounced release.
- key_repeat, out, NUM_KEYS: 1-cycle auto-repeat pulse.
- sw_sync, out, NUM_SW: 2-flop-synchronised switches.
- disp_value, in, 4*NUM_DIGITS: hex nibbles; digit i is bits [4i+3:4i].
- disp_blank, in, NUM_DIGITS: per-digit forced blank.
- disp_load, in, 1: captures disp_value and disp_blank.
- hex_n, out, 7*NUM_DIGITS: active-low segments; digit i is bits [7i+6:7i], bit 0 = a … bit 6 = g.

## Operation

Synchroniser:
- Each key_n and sw bit passes through 2 flops.
- Key synchronisers reset to 1 (released); switch synchronisers reset to 0.

Debounce, per key, with counter width $clog2(DEBOUNCE_CYCLES):
- If the synchronised level equals the stable state, the counter clears.
- Otherwise the counter increments.
- On the cycle the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, the stable state flips and the counter clears.
- Any bounce back to the stable state before that point restarts the count.
- key_level is the inverted stable state. key_press and key_release are registered, 1-cycle, and coincide with the key_level edge.

Repeat FSM, per key, states IDLE, DELAY, RPT, with a counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
- IDLE → DELAY on key_press when repeat_en=1; the counter clears.
- DELAY → RPT when the counter reaches REPEAT_DELAY-1. key_repeat pulses on that cycle and the counter clears.
- RPT: key_repeat pulses each time the counter reaches REPEAT_PERIOD-1, then the counter clears.
- Any state → IDLE, with no pulse, on key_release or on repeat_en=0. This takes priority over a pulse due in the same cycle.
- key_repeat never coincides with key_press.

Display:
- disp_load=1 registers disp_value and disp_blank.
- The next cycle, hex_n is recomputed from the registered copy. hex_n is a registered output.
- Encoding (active-low, gfedcba):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- A blanked digit outputs 1111111.
- Digit i is blanked if disp_blank[i]=1.
- Digit i is also blanked if BLANK_LEADING=1, i>0, and every nibble at index ≥i is 0.
- Digit 0 is never leading-blanked.

## Timing

- Reset values: key_level, key_press, key_release, key_repeat, and sw_sync are all 0. hex_n is all 1s. The display registers hold value 0 and blank mask all 1s. All FSMs are in IDLE. All counters are 0.
- Raw key change that is held stable, to key_level/key_press: 2 + DEBOUNCE_CYCLES cycles.
- Raw sw to sw_sync: 2 cycles.
- key_press to first key_repeat: REPEAT_DELAY cycles. Subsequent repeat pulses are spaced REPEAT_PERIOD cycles apart.
- disp_load to hex_n: 2 cycles (capture, then encode register).
- disp_load held high reloads every cycle.
- reset_n assertion mid-operation: immediately returns everything to the reset values. No pulse is emitted on deassertion.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, NUM_DIGITS=6.

- Reset with key_n=4'hF: all pulses and levels are 0, hex_n is all 1s. The first disp_load of 0 gives digit 0 = 1000000 and digits 1–5 = 1111111.
- Drive key_n[0] low and hold it: key_level[0] and key_press[0] assert 6 cycles later, with key_press[0] exactly 1 cycle wide. Release and hold: key_release[0] pulses 6 cycles after the release.
- Toggle key_n[1] every 2 cycles for 20 cycles: no key_press or key_release pulses occur and key_level[1] stays 0.
- Set repeat_en[2]=1 and hold key 2: key_repeat[2] pulses 8 cycles after key_press, then every 3 cycles. Release: no further pulses. Repeat with repeat_en dropped mid-RPT: pulses stop that cycle.
- Load disp_value=24'h00A05F with disp_blank=0: digits 5–4 are blank; digits 3..0 show A (0001000), 0 (1000000), 5 (0010010), F (0001110). Then load disp_blank=6'b000001: digit 0 blanks.
- Assert reset_n low mid-DELAY with a key held: no key_repeat pulse. After release of reset with the key still held, key_press fires again after 2 + 4 cycles.
